// File: rtl/vga_display_pkg.sv
// Shared definitions for the VGA sprite display: timing defaults,
// derived totals, datapath widths, pipeline latency and a span helper.
package vga_display_pkg;

  // 640x480 @ 60 Hz timing defaults
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 29;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;

  localparam int H_TOT_DEF = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
  localparam int V_TOT_DEF = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;

  localparam int NUM_OBJ_DEF = 4;
  localparam int COLOR_W     = 9;
  localparam int COORD_W     = 10;

  // Cycles from the raster counters to the output pins
  localparam int PIPE_LAT = 2;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [COORD_W-1:0] coord_t;

  // True when start <= pos < start+len, evaluated one bit wider so the
  // end of a span that runs past the screen edge never wraps around.
  function automatic logic in_span(input coord_t start, input coord_t len,
                                   input coord_t pos);
    logic [COORD_W:0] s_ext;
    logic [COORD_W:0] e_ext;
    logic [COORD_W:0] p_ext;
    s_ext = {1'b0, start};
    e_ext = s_ext + {1'b0, len};
    p_ext = {1'b0, pos};
    return (len != {COORD_W{1'b0}}) && (p_ext >= s_ext) && (p_ext < e_ext);
  endfunction

endpackage

// File: rtl/vga_sprite_display_if.sv
// Bus between game logic and the sprite display: object attributes and
// background colour in, VGA pins and the frame pacing pulse out.
interface vga_sprite_display_if #(
  parameter int NUM_OBJ = vga_display_pkg::NUM_OBJ_DEF
);
  import vga_display_pkg::*;

  logic [COORD_W*NUM_OBJ-1:0] obj_x;
  logic [COORD_W*NUM_OBJ-1:0] obj_y;
  logic [COORD_W*NUM_OBJ-1:0] obj_w;
  logic [COORD_W*NUM_OBJ-1:0] obj_h;
  logic [COLOR_W*NUM_OBJ-1:0] obj_color;
  logic [NUM_OBJ-1:0]         obj_en;
  color_t                     bg_color;

  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [2:0] blue;
  logic       frame_start;

  // Game logic side
  modport master (
    output obj_x, obj_y, obj_w, obj_h, obj_color, obj_en, bg_color,
    input  hsync, vsync, red, green, blue, frame_start
  );

  // Display side
  modport slave (
    input  obj_x, obj_y, obj_w, obj_h, obj_color, obj_en, bg_color,
    output hsync, vsync, red, green, blue, frame_start
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing for the sprite display: horizontal/vertical counters,
// active-area flag, active-relative pixel coordinates, raw syncs and the
// end-of-frame strobe that loads the shadow registers.
module vga_timing_gen
  import vga_display_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF
) (
  input  logic   dclk,
  input  logic   rst,
  output coord_t px,
  output coord_t py,
  output logic   active,
  output logic   hsync_raw,
  output logic   vsync_raw,
  output logic   load
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam coord_t H_LAST     = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOT - 1);
  localparam coord_t H_START    = coord_t'(H_SYNC + H_BP);
  localparam coord_t V_START    = coord_t'(V_SYNC + V_BP);
  localparam coord_t H_END      = coord_t'(H_SYNC + H_BP + H_ACTIVE);
  localparam coord_t V_END      = coord_t'(V_SYNC + V_BP + V_ACTIVE);
  localparam coord_t H_SYNC_END = coord_t'(H_SYNC);
  localparam coord_t V_SYNC_END = coord_t'(V_SYNC);

  coord_t hc;
  coord_t vc;

  // Pixel and line counters; the line counter steps when the pixel counter wraps
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      hc <= {COORD_W{1'b0}};
      vc <= {COORD_W{1'b0}};
    end else if (hc == H_LAST) begin
      hc <= {COORD_W{1'b0}};
      if (vc == V_LAST) begin
        vc <= {COORD_W{1'b0}};
      end else begin
        vc <= vc + 10'd1;
      end
    end else begin
      hc <= hc + 10'd1;
    end
  end

  assign active    = (hc >= H_START) && (hc < H_END) && (vc >= V_START) && (vc < V_END);
  assign px        = hc - H_START;
  assign py        = vc - V_START;
  assign hsync_raw = !(hc < H_SYNC_END);
  assign vsync_raw = !(vc < V_SYNC_END);
  // Last counter position of the frame; its own pixel is still computed
  // from the old shadow set, the new set applies from hc=0, vc=0.
  assign load      = (hc == H_LAST) && (vc == V_LAST);

endmodule

// File: rtl/vga_sprite_display.sv
// VGA raster generator with NUM_OBJ prioritised solid rectangles over a
// background colour. Object attributes are double-buffered and reloaded
// once per frame. Outputs come from a 2-stage registered pipeline.
// Optional feature macro: VGA_BORDER_EN (1-pixel BORDER_COLOR frame
// drawn above everything on the edges of the active area).
module vga_sprite_display
  import vga_display_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int NUM_OBJ  = NUM_OBJ_DEF
`ifdef VGA_BORDER_EN
  , parameter color_t BORDER_COLOR = 9'h1FF
`endif
) (
  input logic dclk,
  input logic rst,
  vga_sprite_display_if.slave bus
);

  coord_t px;
  coord_t py;
  logic   active;
  logic   hsync_raw;
  logic   vsync_raw;
  logic   load;

  vga_timing_gen #(
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP)
  ) u_timing (
    .dclk      (dclk),
    .rst       (rst),
    .px        (px),
    .py        (py),
    .active    (active),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .load      (load)
  );

  // Shadow copies of the object attributes, stable for a whole frame
  coord_t             sh_x     [NUM_OBJ];
  coord_t             sh_y     [NUM_OBJ];
  coord_t             sh_w     [NUM_OBJ];
  coord_t             sh_h     [NUM_OBJ];
  color_t             sh_color [NUM_OBJ];
  logic [NUM_OBJ-1:0] sh_en;
  color_t             sh_bg;

  // Capture all attributes on the end-of-frame strobe; zero means nothing visible
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh_x[i]     <= {COORD_W{1'b0}};
        sh_y[i]     <= {COORD_W{1'b0}};
        sh_w[i]     <= {COORD_W{1'b0}};
        sh_h[i]     <= {COORD_W{1'b0}};
        sh_color[i] <= {COLOR_W{1'b0}};
      end
      sh_en <= {NUM_OBJ{1'b0}};
      sh_bg <= {COLOR_W{1'b0}};
    end else if (load) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh_x[i]     <= bus.obj_x[COORD_W*i +: COORD_W];
        sh_y[i]     <= bus.obj_y[COORD_W*i +: COORD_W];
        sh_w[i]     <= bus.obj_w[COORD_W*i +: COORD_W];
        sh_h[i]     <= bus.obj_h[COORD_W*i +: COORD_W];
        sh_color[i] <= bus.obj_color[COLOR_W*i +: COLOR_W];
      end
      sh_en <= bus.obj_en;
      sh_bg <= bus.bg_color;
    end else begin
      sh_en <= sh_en;
    end
  end

  logic [NUM_OBJ-1:0] hit;

  // Per-object rectangle test for the current raster position
  always_comb begin
    hit = {NUM_OBJ{1'b0}};
    for (int i = 0; i < NUM_OBJ; i++) begin
      hit[i] = sh_en[i] & in_span(sh_x[i], sh_w[i], px) & in_span(sh_y[i], sh_h[i], py);
    end
  end

  logic [NUM_OBJ-1:0] hit_s1;
  logic               active_s1;
  logic               hsync_s1;
  logic               vsync_s1;

  // Stage 1: hit vector, active flag and raw syncs
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      hit_s1    <= {NUM_OBJ{1'b0}};
      active_s1 <= 1'b0;
      hsync_s1  <= 1'b1;
      vsync_s1  <= 1'b1;
    end else begin
      hit_s1    <= hit;
      active_s1 <= active;
      hsync_s1  <= hsync_raw;
      vsync_s1  <= vsync_raw;
    end
  end

`ifdef VGA_BORDER_EN
  localparam coord_t PX_LAST = coord_t'(H_ACTIVE - 1);
  localparam coord_t PY_LAST = coord_t'(V_ACTIVE - 1);

  logic border_s1;

  // Stage 1: outermost ring of the active area
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      border_s1 <= 1'b0;
    end else begin
      border_s1 <= active && ((px == 10'd0) || (px == PX_LAST) ||
                             (py == 10'd0) || (py == PY_LAST));
    end
  end
`endif

  color_t pix;

  // Priority pick: walking from the highest index down lets object 0 win.
  // Shadow colours are read here a cycle after the hit test; they only
  // change at the last counter position, which lies in blanking.
  always_comb begin
    pix = sh_bg;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      pix = hit_s1[i] ? sh_color[i] : pix;
    end
`ifdef VGA_BORDER_EN
    pix = border_s1 ? BORDER_COLOR : pix;
`endif
  end

  logic   hsync_r;
  logic   vsync_r;
  color_t rgb_r;
  logic   frame_start_r;

  // Stage 2: pin registers; colour is forced black outside the active area
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
      rgb_r   <= {COLOR_W{1'b0}};
    end else begin
      hsync_r <= hsync_s1;
      vsync_r <= vsync_s1;
      rgb_r   <= active_s1 ? pix : {COLOR_W{1'b0}};
    end
  end

  // Frame pacing pulse, high while the counters sit at hc=0, vc=0 after a load
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= load;
    end
  end

  assign bus.hsync       = hsync_r;
  assign bus.vsync       = vsync_r;
  assign bus.red         = rgb_r[8:6];
  assign bus.green       = rgb_r[5:3];
  assign bus.blue        = rgb_r[2:0];
  assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_sprite_display.sv
// Randomised bench for vga_sprite_display using a reduced raster so many
// frames fit in a short run. Each cycle the pins are compared with a
// reference computed from the frame/line/pixel arithmetic and the scene
// snapshot that was live on the input bus at the end of the prior frame.
module tb_vga_sprite_display;
  import vga_display_pkg::*;

  localparam int HS = 4, HB = 3, HA = 16, HF = 2;
  localparam int VS = 2, VB = 2, VA = 12, VF = 2;
  localparam int NOBJ  = 4;
  localparam int H_TOT = HS + HB + HA + HF;
  localparam int V_TOT = VS + VB + VA + VF;
  localparam int FRAME = H_TOT * V_TOT;

  typedef struct {
    int x[NOBJ];
    int y[NOBJ];
    int w[NOBJ];
    int h[NOBJ];
    int c[NOBJ];
    int en[NOBJ];
    int bg;
  } scene_t;

  logic dclk;
  logic rst;

  vga_sprite_display_if #(.NUM_OBJ(NOBJ)) bus ();

  vga_sprite_display #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .NUM_OBJ(NOBJ)
  ) dut (
    .dclk (dclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  int     checks = 0;
  int     errors = 0;
  int     n      = 0;   // clock edges since reset release
  scene_t cur;
  scene_t hist[40];     // scene shown in each frame since reset release

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic apply_scene();
    for (int i = 0; i < NOBJ; i++) begin
      bus.obj_x[10*i +: 10]    = 10'(cur.x[i]);
      bus.obj_y[10*i +: 10]    = 10'(cur.y[i]);
      bus.obj_w[10*i +: 10]    = 10'(cur.w[i]);
      bus.obj_h[10*i +: 10]    = 10'(cur.h[i]);
      bus.obj_color[9*i +: 9]  = 9'(cur.c[i]);
      bus.obj_en[i]            = (cur.en[i] != 0);
    end
    bus.bg_color = 9'(cur.bg);
  endtask

  task automatic rand_obj(input int i);
    cur.x[i]  = int'($urandom_range(0, 20));
    cur.y[i]  = int'($urandom_range(0, 14));
    cur.w[i]  = int'($urandom_range(0, 10));
    cur.h[i]  = int'($urandom_range(0, 8));
    cur.c[i]  = int'($urandom_range(0, 511));
    cur.en[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
  endtask

  task automatic clear_hist0();
    for (int i = 0; i < NOBJ; i++) begin
      hist[0].x[i] = 0; hist[0].y[i] = 0; hist[0].w[i] = 0;
      hist[0].h[i] = 0; hist[0].c[i] = 0; hist[0].en[i] = 0;
    end
    hist[0].bg = 0;
  endtask

  // Expected pins for raster position p (cycles since reset release)
  function automatic void model(input int p, output logic [1:0] sy, output logic [8:0] rgb);
    int hc, vc, px, py;
    bit found;
    scene_t s;
    hc  = p % H_TOT;
    vc  = (p / H_TOT) % V_TOT;
    s   = hist[p / FRAME];
    sy  = {(hc >= HS) ? 1'b1 : 1'b0, (vc >= VS) ? 1'b1 : 1'b0};
    rgb = 9'h000;
    if (hc >= HS + HB && hc < HS + HB + HA && vc >= VS + VB && vc < VS + VB + VA) begin
      px = hc - (HS + HB);
      py = vc - (VS + VB);
      rgb = 9'(s.bg);
      found = 1'b0;
      for (int i = 0; i < NOBJ; i++) begin
        if (!found && s.en[i] != 0 && px >= s.x[i] && px < s.x[i] + s.w[i]
            && py >= s.y[i] && py < s.y[i] + s.h[i]) begin
          rgb = 9'(s.c[i]);
          found = 1'b1;
        end
      end
`ifdef VGA_BORDER_EN
      if (px == 0 || px == HA - 1 || py == 0 || py == VA - 1) rgb = 9'h1FF;
`endif
    end
  endfunction

  task automatic check_state();
    logic [1:0] sy;
    logic [8:0] rgb;
    if (n < PIPE_LAT) begin
      sy  = 2'b11;
      rgb = 9'h000;
    end else begin
      model(n - PIPE_LAT, sy, rgb);
    end
    check_eq("sync", 32'({bus.hsync, bus.vsync}), 32'(sy));
    check_eq("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(rgb));
    check_eq("frame_start", 32'(bus.frame_start), 32'((n > 0 && n % FRAME == 0) ? 1 : 0));
  endtask

  task automatic run_cycles(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge dclk);
      n++;
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 4) == 0) cur.bg = int'($urandom_range(0, 511));
        else rand_obj(int'($urandom_range(0, NOBJ - 1)));
        apply_scene();
      end
      if ((n + 1) % FRAME == 0) hist[(n + 1) / FRAME] = cur;
      check_state();
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < NOBJ; i++) rand_obj(i);
    cur.bg = int'($urandom_range(1, 511));
    // Directed overlap: object 1 sits exactly under object 0
    cur.x[0] = 3; cur.y[0] = 2; cur.w[0] = 6; cur.h[0] = 4; cur.c[0] = 9'h1FF; cur.en[0] = 1;
    cur.x[1] = 3; cur.y[1] = 2; cur.w[1] = 6; cur.h[1] = 4; cur.c[1] = 9'h1C0; cur.en[1] = 1;
    cur.x[2] = 12; cur.w[2] = 9; cur.en[2] = 1;   // runs past the right edge
    apply_scene();
    #1 rst = 1'b1;
    repeat (3) @(negedge dclk);
    check_eq("reset_sync", 32'({bus.hsync, bus.vsync}), 32'(2'b11));
    check_eq("reset_rgb", 32'({bus.red, bus.green, bus.blue}), 32'(0));
    check_eq("reset_fs", 32'(bus.frame_start), 32'(0));

    rst = 1'b0;
    n = 0;
    clear_hist0();
    check_state();
    run_cycles(3 * FRAME);
    // Disable the top-priority object so object 1 takes over
    cur.en[0] = 0;
    apply_scene();
    run_cycles(9 * FRAME + 37);

    // Asynchronous reset part-way through a line
    @(posedge dclk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_sync", 32'({bus.hsync, bus.vsync}), 32'(2'b11));
    check_eq("async_rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'(0));
    check_eq("async_rst_fs", 32'(bus.frame_start), 32'(0));
    @(negedge dclk);
    rst = 1'b0;
    n = 0;
    clear_hist0();
    check_state();
    run_cycles(10 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
